// File: rtl/keypad_pkg.sv
// Shared key-event definitions for the keypad scanner and the calculator core's decoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_PRESS_DB,
        ST_EMIT,
        ST_RELEASE_DB
    } kp_state_t;

    localparam int unsigned KEY_VALID = 4;
    localparam int unsigned KEY_W     = 5;
    localparam logic [3:0]  ROWS_IDLE = 4'b1111;

    typedef struct packed {
        logic       valid;
        logic [1:0] col;
        logic [1:0] row;
    } key_event_t;

    // Codes are {valid, col, row}.
    localparam logic [KEY_W-1:0] KEY_1   = 5'b1_00_00, KEY_4   = 5'b1_00_01,
                                 KEY_7   = 5'b1_00_10, KEY_0   = 5'b1_00_11,
                                 KEY_2   = 5'b1_01_00, KEY_5   = 5'b1_01_01,
                                 KEY_8   = 5'b1_01_10, KEY_3   = 5'b1_10_00,
                                 KEY_6   = 5'b1_10_01, KEY_9   = 5'b1_10_10,
                                 KEY_EQ  = 5'b1_11_00, KEY_ADD = 5'b1_11_01,
                                 KEY_SUB = 5'b1_11_10, KEY_MUL = 5'b1_11_11;

    function automatic logic one_cold(input logic [3:0] v);
        return ($countones(~v) == 1);
    endfunction

    function automatic logic [1:0] cold_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; idles at all-ones.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, press/release debounce, one pulse per press.
// Optional auto-repeat while held when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] columns,
    output logic [4:0] value
);

    localparam int unsigned SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // Settings the scan and repeat timing cannot represent.
    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_params
    end

    logic [3:0]    rs;
    kp_state_t     state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    pat_q, pat_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [DW-1:0] db_q, db_d;
    logic [3:0]    columns_q;
    key_event_t    evt_q, evt_d;
    key_event_t    held_key;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HW       = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    logic [HW-1:0] hold_q, hold_d;
    logic          rep_q, rep_d;
`endif

    sync_2ff #(.WIDTH(4)) u_rows_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (rows),
        .q_o   (rs)
    );

    assign held_key = '{valid: 1'b1, col: col_q, row: cold_index(pat_q)};

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        pat_d   = pat_q;
        slot_d  = slot_q;
        db_d    = db_q;
        evt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
        hold_d  = hold_q;
        rep_d   = rep_q;
`endif
        case (state_q)
            ST_SCAN: begin
                if (slot_q == SW'(SCAN_DIV - 1)) begin
                    slot_d = '0;
                    if (one_cold(rs)) begin
                        state_d = ST_PRESS_DB;
                        pat_d   = rs;
                        db_d    = '0;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            ST_PRESS_DB: begin
                if (rs != pat_q) begin
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                    slot_d  = '0;
                end else if (db_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = ST_EMIT;
                    evt_d   = held_key;
                end else begin
                    db_d = db_q + DW'(1);
                end
            end
            ST_EMIT: begin
                state_d = ST_RELEASE_DB;
                db_d    = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                // The emit cycle itself counts as the first held cycle.
                hold_d  = HW'(1);
                rep_d   = 1'b0;
`endif
            end
            ST_RELEASE_DB: begin
                if (rs != ROWS_IDLE) begin
                    db_d = '0;
                end else if (db_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                    slot_d  = '0;
                end else begin
                    db_d = db_q + DW'(1);
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                if (rs != pat_q) begin
                    hold_d = '0;
                    rep_d  = 1'b0;
                end else if (hold_q == (rep_q ? HW'(REPEAT_PERIOD - 1) : HW'(REPEAT_DELAY - 1))) begin
                    evt_d  = held_key;
                    hold_d = '0;
                    rep_d  = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_SCAN;
            col_q     <= 2'd0;
            pat_q     <= ROWS_IDLE;
            slot_q    <= '0;
            db_q      <= '0;
            columns_q <= 4'b1110;
            evt_q     <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            pat_q     <= pat_d;
            slot_q    <= slot_d;
            db_q      <= db_d;
            columns_q <= ~(4'b0001 << col_d);
            evt_q     <= evt_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_q <= '0;
            rep_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end
`endif

    assign columns = columns_q;
    assign value   = evt_q;

endmodule
